// File: rtl/buscaminas_pkg.sv
// Shared encodings for the minesweeper board: controller states, per-cell
// display states and command opcodes.
package buscaminas_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StPlay,
        StCascade,
        StWon,
        StLost
    } state_e;

    localparam logic [1:0] HIDDEN   = 2'b00;
    localparam logic [1:0] REVEALED = 2'b01;
    localparam logic [1:0] FLAGGED  = 2'b10;

    localparam logic OP_REVEAL = 1'b0;
    localparam logic OP_FLAG   = 1'b1;

endpackage

// File: rtl/buscaminas_vecinos.sv
// Counts set bits of a cell map among the up-to-8 in-board neighbours of
// (row_i, col_i); the cell itself and off-board positions are excluded.
module buscaminas_vecinos #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned CW = $clog2(COLS),
    localparam int unsigned N  = ROWS * COLS
) (
    input  logic [N-1:0]  mines_i,
    input  logic [RW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    output logic [3:0]    count_o
);

    always_comb begin
        int r;
        int c;
        logic [N-1:0] sh;
        count_o = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r  = int'(row_i) + dr;
                c  = int'(col_i) + dc;
                // Out-of-board shifts are never used; the guard below clips them.
                sh = mines_i >> (r * int'(COLS) + c);
                if (!(dr == 0 && dc == 0) && r >= 0 && r < int'(ROWS) &&
                    c >= 0 && c < int'(COLS) && sh[0]) begin
                    count_o = count_o + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/buscaminas_tablero.sv
// Minesweeper board controller: loads a mine map, computes neighbour counts one
// cell per cycle, then executes reveal/flag commands with flood-fill cascade.
module buscaminas_tablero
    import buscaminas_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned CW = $clog2(COLS),
    localparam int unsigned N  = ROWS * COLS,
    localparam int unsigned NW = $clog2(N + 1),
    localparam int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N-1:0]    mines_in,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic [RW-1:0]   cmd_row,
    input  logic [CW-1:0]   cmd_col,
    output logic [2*N-1:0]  cell_state,
    output logic [4*N-1:0]  cell_count,
    output logic [NW-1:0]   revealed_cnt,
    output logic [NW-1:0]   flag_cnt,
    output logic            busy,
    output logic            game_over,
    output logic            win
);

    state_e         state_q, state_d;
    logic [N-1:0]   mines_q, mines_d;
    logic [1:0]     cell_q [N];
    logic [3:0]     cnt_q  [N];
    logic [IW-1:0]  idx_q, idx_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic           changed_q, changed_d;
    logic [NW-1:0]  rev_q, rev_d;
    logic [NW-1:0]  flag_q, flag_d;

    logic           clear_cells;
    logic           cell_we;
    logic [IW-1:0]  cell_widx;
    logic [1:0]     cell_wval;
    logic           cnt_we;

    logic           last;
    logic [IW-1:0]  nxt_idx;
    logic [RW-1:0]  nxt_row;
    logic [CW-1:0]  nxt_col;

    logic [3:0]     mine_cnt;
    logic [3:0]     open_cnt;
    logic [N-1:0]   zero_open;
    logic [NW-1:0]  num_mines;
    logic [NW-1:0]  safe_total;
    logic           all_safe;

    logic           cmd_in_range;
    logic [IW-1:0]  cmd_idx;
    logic [1:0]     cmd_cell;
    logic           reveal_now;

    buscaminas_vecinos #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_minas (
        .mines_i (mines_q),
        .row_i   (row_q),
        .col_i   (col_q),
        .count_o (mine_cnt)
    );

    // A non-zero result here means the scanned cell touches an opened empty cell.
    buscaminas_vecinos #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_abiertas (
        .mines_i (zero_open),
        .row_i   (row_q),
        .col_i   (col_q),
        .count_o (open_cnt)
    );

    always_comb begin
        num_mines = '0;
        for (int i = 0; i < int'(N); i++) begin
            zero_open[i] = (cell_q[i] == REVEALED) && (cnt_q[i] == 4'd0) && !mines_q[i];
            num_mines    = num_mines + NW'(mines_q[i]);
        end
        safe_total = NW'(N) - num_mines;
        all_safe   = (rev_q == safe_total);
    end

    always_comb begin
        last = (idx_q == IW'(N - 1));
        if (last) begin
            nxt_idx = '0;
            nxt_row = '0;
            nxt_col = '0;
        end else begin
            nxt_idx = idx_q + IW'(1);
            if (col_q == CW'(COLS - 1)) begin
                nxt_col = '0;
                nxt_row = row_q + RW'(1);
            end else begin
                nxt_col = col_q + CW'(1);
                nxt_row = row_q;
            end
        end
    end

    always_comb begin
        cmd_in_range = (32'(cmd_row) < ROWS) && (32'(cmd_col) < COLS);
        cmd_idx      = IW'(cmd_row) * IW'(COLS) + IW'(cmd_col);
        cmd_cell     = cell_q[cmd_idx];
        reveal_now   = (cell_q[idx_q] == HIDDEN) && !mines_q[idx_q] && (open_cnt != 4'd0);
    end

    always_comb begin
        state_d     = state_q;
        mines_d     = mines_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        changed_d   = changed_q;
        rev_d       = rev_q;
        flag_d      = flag_q;
        clear_cells = 1'b0;
        cell_we     = 1'b0;
        cell_widx   = idx_q;
        cell_wval   = HIDDEN;
        cnt_we      = 1'b0;
        cmd_ready   = 1'b0;

        unique case (state_q)
            StIdle, StWon, StLost, StPlay: begin
                if (start) begin
                    mines_d     = mines_in;
                    clear_cells = 1'b1;
                    rev_d       = '0;
                    flag_d      = '0;
                    idx_d       = '0;
                    row_d       = '0;
                    col_d       = '0;
                    changed_d   = 1'b0;
                    state_d     = StCount;
                end else if (state_q == StPlay) begin
                    if (all_safe) begin
                        state_d = StWon;
                    end else begin
                        cmd_ready = 1'b1;
                        if (cmd_valid && cmd_in_range) begin
                            cell_widx = cmd_idx;
                            if (cmd_op == OP_FLAG) begin
                                if (cmd_cell == HIDDEN) begin
                                    cell_we   = 1'b1;
                                    cell_wval = FLAGGED;
                                    flag_d    = flag_q + NW'(1);
                                end else if (cmd_cell == FLAGGED) begin
                                    cell_we   = 1'b1;
                                    cell_wval = HIDDEN;
                                    flag_d    = flag_q - NW'(1);
                                end
                            end else if (cmd_cell == HIDDEN) begin
                                cell_we   = 1'b1;
                                cell_wval = REVEALED;
                                if (mines_q[cmd_idx]) begin
                                    state_d = StLost;
                                end else begin
                                    rev_d = rev_q + NW'(1);
                                    if (cnt_q[cmd_idx] == 4'd0) begin
                                        state_d   = StCascade;
                                        idx_d     = '0;
                                        row_d     = '0;
                                        col_d     = '0;
                                        changed_d = 1'b0;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            StCount: begin
                cnt_we = 1'b1;
                idx_d  = nxt_idx;
                row_d  = nxt_row;
                col_d  = nxt_col;
                if (last) begin
                    state_d = StPlay;
                end
            end
            StCascade: begin
                if (reveal_now) begin
                    cell_we   = 1'b1;
                    cell_wval = REVEALED;
                    rev_d     = rev_q + NW'(1);
                    changed_d = 1'b1;
                end
                idx_d = nxt_idx;
                row_d = nxt_row;
                col_d = nxt_col;
                if (last) begin
                    changed_d = 1'b0;
                    if (!(changed_q || reveal_now)) begin
                        state_d = all_safe ? StWon : StPlay;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mines_q   <= '0;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            changed_q <= 1'b0;
            rev_q     <= '0;
            flag_q    <= '0;
            for (int i = 0; i < int'(N); i++) begin
                cell_q[i] <= HIDDEN;
                cnt_q[i]  <= 4'd0;
            end
        end else begin
            state_q   <= state_d;
            mines_q   <= mines_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            changed_q <= changed_d;
            rev_q     <= rev_d;
            flag_q    <= flag_d;
            if (clear_cells) begin
                for (int i = 0; i < int'(N); i++) begin
                    cell_q[i] <= HIDDEN;
                    cnt_q[i]  <= 4'd0;
                end
            end else begin
                if (cell_we) begin
                    cell_q[cell_widx] <= cell_wval;
                end
                if (cnt_we) begin
                    cnt_q[idx_q] <= mine_cnt;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            cell_state[2*i +: 2] = cell_q[i];
            cell_count[4*i +: 4] = cnt_q[i];
        end
        revealed_cnt = rev_q;
        flag_cnt     = flag_q;
        busy         = (state_q == StCount) || (state_q == StCascade);
        game_over    = (state_q == StWon) || (state_q == StLost);
        win          = (state_q == StWon);
    end

endmodule
